// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and constants for the registered 8-bit ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SH_W   = $clog2(DATA_W);

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_MOD  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_XNOR = 4'd8,
    OP_NOT  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_ROL  = 4'd12,
    OP_ROR  = 4'd13,
    OP_CMP  = 4'd14,
    OP_MAX  = 4'd15
  } alu_op_e;

  localparam logic [DATA_W-1:0] DIV0_RESULT = 8'hFF;

  // Bit positions of the one-hot compare result.
  localparam int unsigned CMP_GT_BIT = 0;
  localparam int unsigned CMP_EQ_BIT = 1;
  localparam int unsigned CMP_LT_BIT = 2;

  // Rotate via a doubled operand so a zero amount needs no special case.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] a,
                                             input logic [SH_W-1:0]   sh);
    logic [2*DATA_W-1:0] dbl;
    dbl  = {a, a} << sh;
    rotl = dbl[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] a,
                                             input logic [SH_W-1:0]   sh);
    logic [2*DATA_W-1:0] dbl;
    dbl  = {a, a} >> sh;
    rotr = dbl[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/alu_datapath.sv
// Purely combinational ALU function f(op, a, b); every opcode is defined.
module alu_datapath
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_c
);

  logic [SH_W-1:0]   sh_amt;
  logic              b_zero;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] cmp_vec;
  alu_op_e           op;

  assign op     = alu_op_e'(op_i);
  assign sh_amt = b_i[SH_W-1:0];
  assign b_zero = (b_i == '0);

  // Divider operand forced to 1 on zero so the raw quotient never sees b==0.
  always_comb begin
    logic [DATA_W-1:0] div_b;
    div_b = b_zero ? DATA_W'(1) : b_i;
    quot  = a_i / div_b;
    rem   = a_i % div_b;
  end

  always_comb begin
    cmp_vec             = '0;
    cmp_vec[CMP_GT_BIT] = (a_i > b_i);
    cmp_vec[CMP_EQ_BIT] = (a_i == b_i);
    cmp_vec[CMP_LT_BIT] = (a_i < b_i);
  end

  always_comb begin
    res_c = '0;
    case (op)
      OP_ADD:  res_c = a_i + b_i;
      OP_SUB:  res_c = a_i - b_i;
      OP_MUL:  res_c = a_i * b_i;
      OP_DIV:  res_c = b_zero ? DIV0_RESULT : quot;
      OP_MOD:  res_c = b_zero ? a_i : rem;
      OP_AND:  res_c = a_i & b_i;
      OP_OR:   res_c = a_i | b_i;
      OP_XOR:  res_c = a_i ^ b_i;
      OP_XNOR: res_c = ~(a_i ^ b_i);
      OP_NOT:  res_c = ~a_i;
      OP_SHL:  res_c = a_i << sh_amt;
      OP_SHR:  res_c = a_i >> sh_amt;
      OP_ROL:  res_c = rotl(a_i, sh_amt);
      OP_ROR:  res_c = rotr(a_i, sh_amt);
      OP_CMP:  res_c = cmp_vec;
      OP_MAX:  res_c = (a_i > b_i) ? a_i : b_i;
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: strobe-qualified capture of the datapath result, async active-low reset.
module alu
  import alu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              data_in,
  input  logic [DATA_W-1:0] input_a,
  input  logic [DATA_W-1:0] input_b,
  input  logic [OP_W-1:0]   operator,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] dp_res;

  alu_datapath u_datapath (
    .op_i  (operator),
    .a_i   (input_a),
    .b_i   (input_b),
    .res_c (dp_res)
  );

  always_comb begin
    result_d = result_q;
    if (data_in) result_d = dp_res;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) result_q <= '0;
    else        result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU with hand-computed expectations.
module tb_alu;
  import alu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              strobe;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] res;

  int n_checks;
  int n_errors;

  alu dut (
    .clock    (clk),
    .reset    (rst_n),
    .data_in  (strobe),
    .input_a  (a),
    .input_b  (b),
    .operator (op),
    .result   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, sample 1ns after the capturing rising edge.
  task automatic run_op(input string tag, input logic [OP_W-1:0] o,
                        input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb,
                        input logic [DATA_W-1:0] exp);
    @(negedge clk);
    strobe = 1'b1;
    op     = o;
    a      = va;
    b      = vb;
    @(posedge clk);
    #1;
    check(tag, res, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    strobe   = 1'b1;
    op       = OP_ADD;
    a        = 8'h12;
    b        = 8'h34;

    // Reset held with a live strobe: output must stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", res, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_add", res, 8'h46);

    run_op("add_wrap", OP_ADD, 8'hF0, 8'h20, 8'h10);
    run_op("sub_wrap", OP_SUB, 8'h05, 8'h0A, 8'hFB);
    run_op("mul_trunc", OP_MUL, 8'h10, 8'h11, 8'h10);
    run_op("div", OP_DIV, 8'h64, 8'h07, 8'h0E);
    run_op("div_zero", OP_DIV, 8'h64, 8'h00, 8'hFF);
    run_op("mod", OP_MOD, 8'h64, 8'h07, 8'h02);
    run_op("mod_zero", OP_MOD, 8'h64, 8'h00, 8'h64);
    run_op("shl", OP_SHL, 8'h81, 8'h09, 8'h02);
    run_op("shr", OP_SHR, 8'h81, 8'h09, 8'h40);
    run_op("rol", OP_ROL, 8'h81, 8'h09, 8'h03);
    run_op("ror", OP_ROR, 8'h81, 8'h09, 8'hC0);
    run_op("rol_zero", OP_ROL, 8'h81, 8'h08, 8'h81);
    run_op("shl_by7", OP_SHL, 8'h03, 8'h07, 8'h80);
    run_op("ror_by3", OP_ROR, 8'h0F, 8'h03, 8'hE1);
    run_op("cmp_lt", OP_CMP, 8'h03, 8'h07, 8'h04);
    run_op("cmp_eq", OP_CMP, 8'h07, 8'h07, 8'h02);
    run_op("cmp_gt", OP_CMP, 8'h09, 8'h07, 8'h01);
    run_op("max", OP_MAX, 8'h03, 8'h07, 8'h07);
    run_op("max_swap", OP_MAX, 8'hC8, 8'h07, 8'hC8);
    run_op("xnor", OP_XNOR, 8'hF0, 8'hCC, 8'hC3);
    run_op("not", OP_NOT, 8'h0F, 8'h55, 8'hF0);

    // Hold: strobe low ignores new operands/opcode.
    run_op("hold_setup", OP_ADD, 8'h01, 8'h01, 8'h02);
    @(negedge clk);
    strobe = 1'b0;
    op     = OP_MUL;
    a      = 8'hFF;
    b      = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("hold", res, 8'h02);
    end

    // Back-to-back strobes on consecutive cycles.
    run_op("b2b_and", OP_AND, 8'hAA, 8'h0F, 8'h0A);
    run_op("b2b_or",  OP_OR,  8'hAA, 8'h0F, 8'hAF);
    run_op("b2b_xor", OP_XOR, 8'hAA, 8'h0F, 8'hA5);

    // Asynchronous clear between edges.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_clear", res, 8'h00);
    @(posedge clk);
    #1;
    check("reset_discards_op", res, 8'h00);
    @(negedge clk);
    rst_n  = 1'b1;
    strobe = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", res, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
